// File: rtl/mem_rd_ctrl.sv
// mem_rd_ctrl: streams num_row SRAM rows to the systolic array through an output+skid pair.
// Define MEM_RD_PERF_CNT_EN to add the 16-bit stall_cnt performance counter port.
module mem_rd_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ARRAY_DIM  = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic [DATA_WIDTH-1:0]            num_row_in,
   input  logic [ADDR_WIDTH-1:0]            base_addr,
   input  logic                             stall,
   output logic                             mem_rd_en,
   output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
   input  logic [DATA_WIDTH*ARRAY_DIM-1:0]  mem_rd_data,
   output logic [DATA_WIDTH*ARRAY_DIM-1:0]  data_out,
   output logic                             data_valid,
   output logic                             busy,
   output logic                             done
`ifdef MEM_RD_PERF_CNT_EN
   ,
   output logic [15:0]                      stall_cnt
`endif
);

   localparam int RW = DATA_WIDTH * ARRAY_DIM;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] num_q, num_d;
   logic [DATA_WIDTH-1:0] iss_q, iss_d;
   logic [DATA_WIDTH-1:0] cons_q, cons_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rd_en_q, rd_en_d;
   logic [RW-1:0]         out_q, out_d;
   logic                  ov_q, ov_d;
   logic [RW-1:0]         skid_q, skid_d;
   logic                  sv_q, sv_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  consume;
   logic [1:0]            occ;
   logic [1:0]            occ_left;

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      iss_d   = iss_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      rd_en_d = 1'b0;
      out_d   = out_q;
      ov_d    = ov_q;
      skid_d  = skid_q;
      sv_d    = sv_q;

      consume  = ov_q && !stall;
      occ      = {1'b0, ov_q} + {1'b0, sv_q} + {1'b0, rd_en_q};
      occ_left = occ - {1'b0, consume};
      cons_d   = cons_q + {{(DATA_WIDTH-1){1'b0}}, consume};

      // A read decided here is visible next cycle and lands one cycle later,
      // so it may only go out if the row leaving now frees a slot for it.
      unique case (state_q)
         IDLE: begin
            if (en) begin
               num_d  = num_row_in;
               cons_d = '0;
               iss_d  = '0;
               ptr_d  = base_addr;
               if (num_row_in != '0) begin
                  state_d = READ;
                  rd_en_d = 1'b1;
                  addr_d  = base_addr;
                  ptr_d   = base_addr + 1'b1;
                  iss_d   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
               end else begin
                  state_d = DONE;
               end
            end
         end
         READ: begin
            if ((iss_q < num_q) && (occ_left < 2'd2)) begin
               rd_en_d = 1'b1;
               addr_d  = ptr_q;
               ptr_d   = ptr_q + 1'b1;
               iss_d   = iss_q + 1'b1;
            end
            if (iss_d == num_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (cons_d == num_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase

      // Skid row always moves ahead of newly returning data to keep order.
      if (consume) begin
         if (sv_q) begin
            out_d = skid_q;
            ov_d  = 1'b1;
            sv_d  = rd_en_q;
            if (rd_en_q) begin
               skid_d = mem_rd_data;
            end
         end else begin
            ov_d = rd_en_q;
            sv_d = 1'b0;
            if (rd_en_q) begin
               out_d = mem_rd_data;
            end
         end
      end else if (rd_en_q) begin
         if (!ov_q) begin
            out_d = mem_rd_data;
            ov_d  = 1'b1;
         end else begin
            skid_d = mem_rd_data;
            sv_d   = 1'b1;
         end
      end

      busy_d = (state_d != IDLE);
      done_d = (state_q == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         num_q   <= '0;
         iss_q   <= '0;
         cons_q  <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         rd_en_q <= 1'b0;
         out_q   <= '0;
         ov_q    <= 1'b0;
         skid_q  <= '0;
         sv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         iss_q   <= iss_d;
         cons_q  <= cons_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         rd_en_q <= rd_en_d;
         out_q   <= out_d;
         ov_q    <= ov_d;
         skid_q  <= skid_d;
         sv_q    <= sv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign mem_rd_en   = rd_en_q;
   assign mem_rd_addr = addr_q;
   assign data_out    = out_q;
   assign data_valid  = ov_q;
   assign busy        = busy_q;
   assign done        = done_q;

`ifdef MEM_RD_PERF_CNT_EN
   logic [15:0] scnt_q, scnt_d;

   always_comb begin
      scnt_d = scnt_q;
      if ((state_q == IDLE) && en) begin
         scnt_d = '0;
      end else if (ov_q && stall && (scnt_q != 16'hFFFF)) begin
         scnt_d = scnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt_q <= '0;
      end else begin
         scnt_q <= scnt_d;
      end
   end

   assign stall_cnt = scnt_q;
`endif

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// tb_mem_rd_ctrl: directed jobs for mem_rd_ctrl checked every cycle against a
// count-based behavioural model, plus literal timing expectations per job.
module tb_mem_rd_ctrl;

   localparam int DW = 16;
   localparam int AD = 8;
   localparam int AW = 8;
   localparam int RW = DW * AD;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [DW-1:0] num_row_in = '0;
   logic [AW-1:0] base_addr = '0;
   logic          stall = 1'b0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [RW-1:0] mem_rd_data;
   logic [RW-1:0] data_out;
   logic          data_valid;
   logic          busy;
   logic          done;
`ifdef MEM_RD_PERF_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_rd_ctrl #(
      .DATA_WIDTH(DW),
      .ARRAY_DIM (AD),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .num_row_in (num_row_in),
      .base_addr  (base_addr),
      .stall      (stall),
      .mem_rd_en  (mem_rd_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .done       (done)
`ifdef MEM_RD_PERF_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
      logic [RW-1:0] r;
      r = '0;
      for (int k = 0; k < AD; k++) r[k*DW +: DW] = {a, 8'(k)};
      return r;
   endfunction

   // SRAM: data for the strobed address is ready at the following edge.
   always_comb mem_rd_data = mem_rd_en ? row_of(mem_rd_addr) : {AD{16'hDEAD}};

   task automatic chk(input string nm, input logic [RW-1:0] act,
                      input logic [RW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Model state for the cycle being observed.
   int m_act = 0, m_fin = 0, m_done = 0, m_rden = 0;
   int m_num = 0, m_iss = 0, m_land = 0, m_cons = 0, m_scnt = 0;
   logic [AW-1:0] m_base = '0, m_addr = '0;
   int held, take, nr, acc, fin_n, act_n;

   always @(negedge clk) begin
      if (rst) begin
         m_act = 0; m_fin = 0; m_done = 0; m_rden = 0;
         m_num = 0; m_iss = 0; m_land = 0; m_cons = 0; m_scnt = 0;
         m_base = '0; m_addr = '0;
         chk("m_rst_ctl", {busy, done, mem_rd_en, data_valid}, 4'b0);
         chk("m_rst_addr", mem_rd_addr, 0);
         chk("m_rst_data", data_out, 0);
      end else begin
         held = m_land - m_cons;
         chk("m_busy", busy, (m_act != 0) || (m_fin != 0));
         chk("m_done", done, m_done != 0);
         chk("m_rd_en", mem_rd_en, m_rden != 0);
         chk("m_rd_addr", mem_rd_addr, m_addr);
         chk("m_valid", data_valid, held > 0);
         if (held > 0) chk("m_data", data_out, row_of(m_base + AW'(m_cons)));
`ifdef MEM_RD_PERF_CNT_EN
         chk("m_stall_cnt", stall_cnt, m_scnt);
`endif
         take = (held > 0 && !stall) ? 1 : 0;
         acc = (m_act == 0 && m_fin == 0 && en) ? 1 : 0;
         if (acc != 0) begin
            m_num = int'(num_row_in); m_base = base_addr;
            m_iss = 0; m_land = 0; m_cons = 0; m_scnt = 0;
            nr = (m_num != 0) ? 1 : 0;
            fin_n = (m_num == 0) ? 1 : 0;
            act_n = nr;
         end else begin
            nr = (m_act != 0 && m_iss < m_num &&
                  (held + m_rden - take) < 2) ? 1 : 0;
            if (held > 0 && stall && m_scnt < 65535) m_scnt++;
            m_land = m_land + m_rden;
            m_cons = m_cons + take;
            fin_n = (m_act != 0 && m_cons == m_num) ? 1 : 0;
            act_n = (m_act != 0 && m_cons != m_num) ? 1 : 0;
         end
         if (nr != 0) begin
            m_addr = m_base + AW'(m_iss);
            m_iss++;
         end
         m_done = m_fin; m_fin = fin_n; m_act = act_n; m_rden = nr;
      end
   end

   int obs_rd_t[$];
   int obs_rd_a[$];
   int obs_cons[$];
   int obs_v_first, obs_v_last, obs_done_t, obs_done_n;

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // en is driven in relative cycle 0; stall high for cycles slo..shi.
   task automatic run_job(input int num, input int base, input int slo,
                          input int shi, input int en2, input int rstt);
      int t;
      bit fin;
      obs_rd_t.delete(); obs_rd_a.delete(); obs_cons.delete();
      obs_v_first = -1; obs_v_last = -1; obs_done_t = -1; obs_done_n = 0;
      @(posedge clk); #1;
      en = 1'b1;
      num_row_in = DW'(num);
      base_addr = AW'(base);
      stall = (slo <= 0 && 0 <= shi);
      t = 0;
      fin = 0;
      while (!fin && t <= 80) begin
         @(negedge clk);
         if (mem_rd_en) begin
            obs_rd_t.push_back(t);
            obs_rd_a.push_back(int'(mem_rd_addr));
         end
         if (data_valid) begin
            if (obs_v_first < 0) obs_v_first = t;
            obs_v_last = t;
            if (!stall) obs_cons.push_back(int'(data_out[15:8]));
         end
         if (done) begin
            obs_done_n++;
            if (obs_done_t < 0) obs_done_t = t;
            fin = 1;
         end
         if (rstt >= 0 && t >= rstt + 3) fin = 1;
         @(posedge clk); #1;
         t++;
         en = (t == en2);
         if (t == en2) num_row_in = DW'(num + 3);
         stall = (t >= slo && t <= shi);
         if (t == rstt) begin
            rst = 1'b1;
            #1;
            chk("rst_now_ctl", {busy, done, mem_rd_en, data_valid}, 4'b0);
            chk("rst_now_addr", mem_rd_addr, 0);
            chk("rst_now_data", data_out, 0);
         end
         if (t == rstt + 2) rst = 1'b0;
      end
      chk("job_end", fin, 1);
      en = 1'b0;
      stall = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_rd_en", mem_rd_en, 0);
      chk("reset_valid", data_valid, 0);
      chk("reset_addr", mem_rd_addr, 0);
      chk("reset_data", data_out, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Four rows at 0x10, no stall.
      run_job(4, 'h10, -5, -5, -1, -1);
      chk("j1_rd_count", obs_rd_t.size(), 4);
      chk("j1_rd_t0", qat(obs_rd_t, 0), 1);
      chk("j1_rd_t3", qat(obs_rd_t, 3), 4);
      chk("j1_rd_a0", qat(obs_rd_a, 0), 'h10);
      chk("j1_rd_a3", qat(obs_rd_a, 3), 'h13);
      chk("j1_v_first", obs_v_first, 2);
      chk("j1_v_last", obs_v_last, 5);
      chk("j1_done_t", obs_done_t, 7);
      chk("j1_done_n", obs_done_n, 1);

      // Address wrap.
      run_job(3, 'hFE, -5, -5, -1, -1);
      chk("j2_rd_a0", qat(obs_rd_a, 0), 'hFE);
      chk("j2_rd_a1", qat(obs_rd_a, 1), 'hFF);
      chk("j2_rd_a2", qat(obs_rd_a, 2), 'h00);
      chk("j2_cons0", qat(obs_cons, 0), 'hFE);
      chk("j2_cons1", qat(obs_cons, 1), 'hFF);
      chk("j2_cons2", qat(obs_cons, 2), 'h00);

      // Back-pressure for cycles 3-7.
      run_job(6, 'h20, 3, 7, -1, -1);
      chk("j3_rd_count", obs_rd_t.size(), 6);
      chk("j3_rd_t2", qat(obs_rd_t, 2), 3);
      chk("j3_rd_t3", qat(obs_rd_t, 3), 9);
      chk("j3_cons_n", obs_cons.size(), 6);
      for (int i = 0; i < 6; i++) chk("j3_cons_order", qat(obs_cons, i), 'h20 + i);
      chk("j3_v_last", obs_v_last, 12);
      chk("j3_done_t", obs_done_t, 14);
`ifdef MEM_RD_PERF_CNT_EN
      chk("j3_stall_cnt", stall_cnt, 5);
`endif

      // Empty job.
      run_job(0, 'h55, -5, -5, -1, -1);
      chk("j4_done_t", obs_done_t, 2);
      chk("j4_rd_count", obs_rd_t.size(), 0);
      chk("j4_v_first", obs_v_first, -1);

      // Second en during READ with a different count.
      run_job(5, 'h40, -5, -5, 2, -1);
      chk("j5_cons_n", obs_cons.size(), 5);
      chk("j5_done_t", obs_done_t, 8);
      chk("j5_done_n", obs_done_n, 1);

      // Reset while draining, then a clean job.
      run_job(4, 'h80, -5, -5, -1, 5);
      chk("j6_no_done", obs_done_n, 0);
      run_job(2, 'h90, -5, -5, -1, -1);
      chk("j7_done_t", obs_done_t, 5);
      chk("j7_cons0", qat(obs_cons, 0), 'h90);
      chk("j7_cons1", qat(obs_cons, 1), 'h91);

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
